ps2_scancode_rx: RTL and testbench
==================================

// Module: ps2_scancode_rx
// PURPOSE
//  Decodes PS/2 keyboard serial frames (device-to-host) into single-clock scancode events.
//  Drives the machine's keyboard port: kstb strobe, make/break flag, 8-bit set-2 code.
//  Absorbs the F0 (break) and E0 (extended) prefixes so the matrix logic sees one event per key.
//  Sits between the PS/2 pins and the keyboard matrix, in the 56 MHz system domain.
// PARAMETERS
//  FILTER   8       cycles ps2ck must hold a new synchronised level before it is accepted
//  TIMEOUT  112000  cycles without a filtered ps2ck falling edge before a partial frame is dropped (~2 ms)
// PORTS
//  clock  in   1  system clock, 56 MHz
//  reset  in   1  synchronous reset, active-low
//  ps2ck  in   1  PS/2 clock pin, asynchronous
//  ps2d   in   1  PS/2 data pin, asynchronous
//  kstb   out  1  one-cycle strobe: make/code/ext valid
//  make   out  1  1 = press, 0 = release (F0 seen)
//  code   out  8  scancode byte
//  ext    out  1  1 = E0 prefix preceded code
//  perr   out  1  one-cycle strobe: parity, stop or timeout error
// BEHAVIOUR
//  - Reset (reset=0 at clock edge): kstb=0, perr=0, make=1, code=8'h00, ext=0. FSM IDLE, prefixes cleared.
//  - ps2ck and ps2d pass through 2-flop synchronisers.
//  - ps2ck filter: level changes only after FILTER consecutive equal samples. Sample ps2d on filtered 1->0.
//  - FSM, advanced on each filtered falling edge:
//    IDLE:   ps2d=0 -> DATA, bitcnt=0. ps2d=1 -> stay IDLE (glitch, silent).
//    DATA:   shift ps2d into bit 7, shifting right (LSB first). After 8th bit -> PARITY.
//    PARITY: latch bit. Required: data^parity has odd total ones -> STOP.
//    STOP:   ps2d=1 and parity ok -> byte accepted. Otherwise perr pulse, prefixes cleared. Always -> IDLE.
//  - Accepted byte handling:
//    F0 -> brk=1, no strobe.
//    E0 -> ext flag (see CONFIGURATION), no strobe.
//    E1 -> discarded, no strobe.
//    Any other byte -> code<=byte, make<=~brk, ext<=extflag, kstb=1; brk and extflag cleared.
//  - Latency: kstb rises at clock edge FILTER+3 after the stop-bit ps2ck pin fall. Held exactly 1 cycle.
//  - make/code/ext hold their values until the next kstb.
//  - Timeout counter resets on every filtered edge. Counts only when FSM != IDLE.
//    At TIMEOUT: FSM -> IDLE, bitcnt=0, prefixes cleared, perr pulse.
//  - Prefixes persist across frames only until a code strobe, error or timeout.
//  - reset low mid-frame: frame abandoned. A frame already in flight on the pins is not decoded.
//    Its trailing edges fail the start-bit check or end in a stop/parity error.
// CONFIGURATION
//  PS2_EXTENDED_EN defined: E0 sets extflag; ext output reports it with the following code.
//  PS2_EXTENDED_EN undefined: E0 byte discarded silently. ext tied 0.
//    E0-prefixed codes strobe as their base code; "E0 F0 75" gives make=0, code=75.
// TESTING
//  1. Frame 1C, parity 0, stop 1 -> one kstb, make=1, code=8'h1C, ext=0, perr never high.
//  2. F0 then 1C -> single kstb (none on F0), make=0, code=8'h1C.
//  3. E0 75 with PS2_EXTENDED_EN -> kstb, make=1, code=8'h75, ext=1.
//     E0 F0 75 -> make=0, ext=1. Without macro: same strobes, ext=0.
//  4. 1C with parity=1 -> no kstb, one perr pulse. Then good frame 29 -> kstb, code=8'h29, make=1.
//  5. Start + 4 data bits, stall TIMEOUT+10 cycles -> perr pulse, FSM IDLE.
//     Then full frame 5A -> kstb, code=8'h5A.
//  6. reset=0 for 1 cycle after 6 bits of F0 -> outputs at reset values, prefix not applied.
//     Next frames 1C -> make=1, code=8'h1C.
//  7. 2-cycle ps2ck low glitch during IDLE with FILTER=8 -> no state change, no strobe.

Source files
------------

// File: rtl/ps2_scancode_rx_if.sv
// Scancode event bus from the PS/2 receiver to the keyboard matrix logic.
interface ps2_scancode_rx_if;
    logic       kstb;
    logic       make;
    logic [7:0] code;
    logic       ext;
    logic       perr;

    modport master (output kstb, make, code, ext, perr);
    modport slave  (input  kstb, make, code, ext, perr);
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver producing one strobe per key event (set-2 codes).
// Optional feature macro PS2_EXTENDED_EN: report the E0 prefix on ext; otherwise E0 is dropped.
module ps2_scancode_rx #(
    parameter int unsigned FILTER  = 8,
    parameter int unsigned TIMEOUT = 112000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ps2ck,
    input  logic              ps2d,
    ps2_scancode_rx_if.master bus
);
    localparam int unsigned FW = $clog2(FILTER + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic          ck_s1_q, ck_s2_q, d_s1_q, d_s2_q;
    logic          ck_filt_q, ck_filt_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic          flt_edge;
    logic          fall_q, fall_d;
    logic          bit_q, bit_d;

    state_e        state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          brk_q, brk_d;
    logic          kstb_q, kstb_d;
    logic          perr_q, perr_d;
    logic          make_q, make_d;
    logic [7:0]    code_q, code_d;
`ifdef PS2_EXTENDED_EN
    logic          extflag_q, extflag_d;
    logic          ext_q, ext_d;
`endif

    // Glitch filter: a new ps2ck level must persist FILTER samples; the data bit is captured
    // together with the accepted falling edge so the FSM sees both one cycle later.
    always_comb begin
        ck_filt_d = ck_filt_q;
        flt_cnt_d = '0;
        flt_edge  = 1'b0;
        fall_d    = 1'b0;
        bit_d     = bit_q;
        if (ck_s2_q != ck_filt_q) begin
            if (flt_cnt_q == FW'(FILTER - 1)) begin
                ck_filt_d = ck_s2_q;
                flt_edge  = 1'b1;
                fall_d    = ck_filt_q;
                bit_d     = d_s2_q;
            end else begin
                flt_cnt_d = flt_cnt_q + FW'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        brk_d     = brk_q;
        make_d    = make_q;
        code_d    = code_q;
        kstb_d    = 1'b0;
        perr_d    = 1'b0;
`ifdef PS2_EXTENDED_EN
        extflag_d = extflag_q;
        ext_d     = ext_q;
`endif
        if (state_q == StIdle || flt_edge) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end

        if (fall_q) begin
            case (state_q)
                StIdle: begin
                    if (!bit_q) begin
                        state_d  = StData;
                        bitcnt_d = 3'd0;
                    end
                end
                StData: begin
                    shreg_d  = {bit_q, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    par_d   = bit_q;
                    state_d = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (bit_q && (^{shreg_q, par_q})) begin
                        case (shreg_q)
                            8'hF0: brk_d = 1'b1;
                            8'hE0: begin
`ifdef PS2_EXTENDED_EN
                                extflag_d = 1'b1;
`endif
                            end
                            8'hE1: begin
                            end
                            default: begin
                                code_d    = shreg_q;
                                make_d    = ~brk_q;
                                kstb_d    = 1'b1;
                                brk_d     = 1'b0;
`ifdef PS2_EXTENDED_EN
                                ext_d     = extflag_q;
                                extflag_d = 1'b0;
`endif
                            end
                        endcase
                    end else begin
                        perr_d    = 1'b1;
                        brk_d     = 1'b0;
`ifdef PS2_EXTENDED_EN
                        extflag_d = 1'b0;
`endif
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle && to_cnt_q == TW'(TIMEOUT - 1)) begin
            // Line stalled mid-frame: drop the partial byte and any pending prefix.
            state_d   = StIdle;
            bitcnt_d  = 3'd0;
            brk_d     = 1'b0;
            perr_d    = 1'b1;
`ifdef PS2_EXTENDED_EN
            extflag_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ck_s1_q   <= 1'b1;
            ck_s2_q   <= 1'b1;
            d_s1_q    <= 1'b1;
            d_s2_q    <= 1'b1;
            ck_filt_q <= 1'b1;
            flt_cnt_q <= '0;
            fall_q    <= 1'b0;
            bit_q     <= 1'b1;
            state_q   <= StIdle;
            bitcnt_q  <= 3'd0;
            shreg_q   <= 8'h00;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
            brk_q     <= 1'b0;
            kstb_q    <= 1'b0;
            perr_q    <= 1'b0;
            make_q    <= 1'b1;
            code_q    <= 8'h00;
`ifdef PS2_EXTENDED_EN
            extflag_q <= 1'b0;
            ext_q     <= 1'b0;
`endif
        end else begin
            ck_s1_q   <= ps2ck;
            ck_s2_q   <= ck_s1_q;
            d_s1_q    <= ps2d;
            d_s2_q    <= d_s1_q;
            ck_filt_q <= ck_filt_d;
            flt_cnt_q <= flt_cnt_d;
            fall_q    <= fall_d;
            bit_q     <= bit_d;
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            to_cnt_q  <= to_cnt_d;
            brk_q     <= brk_d;
            kstb_q    <= kstb_d;
            perr_q    <= perr_d;
            make_q    <= make_d;
            code_q    <= code_d;
`ifdef PS2_EXTENDED_EN
            extflag_q <= extflag_d;
            ext_q     <= ext_d;
`endif
        end
    end

    assign bus.kstb = kstb_q;
    assign bus.perr = perr_q;
    assign bus.make = make_q;
    assign bus.code = code_q;
`ifdef PS2_EXTENDED_EN
    assign bus.ext  = ext_q;
`else
    assign bus.ext  = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: bit-level PS/2 frame driver with an expected-event scoreboard.
module tb_ps2_scancode_rx;
    localparam int unsigned FILTER  = 8;
    localparam int unsigned TIMEOUT = 3000;
    localparam int          HALF    = 20;
`ifdef PS2_EXTENDED_EN
    localparam logic EXT_EN = 1'b1;
`else
    localparam logic EXT_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic ps2ck = 1'b1;
    logic ps2d  = 1'b1;

    ps2_scancode_rx_if bus ();

    ps2_scancode_rx #(
        .FILTER (FILTER),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ps2ck(ps2ck),
        .ps2d (ps2d),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] code;
        logic       make;
        logic       ext;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  exp_ev;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   kstb_cnt     = 0;
    int   perr_cnt     = 0;
    int   cyc          = 0;
    int   fall_cyc     = 0;
    int   kstb_cyc     = 0;
    logic kstb_prev    = 1'b0;
    logic perr_prev    = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard monitor: every strobe pops one expected event; pulses must last one cycle.
    always @(negedge clock) begin
        if (kstb_prev === 1'b1) begin
            tests_run++;
            if (bus.kstb !== 1'b0) begin
                tests_failed++;
                $display("FAIL kstb_width: kstb=%b on 2nd cycle, required 0", bus.kstb);
            end
        end
        if (perr_prev === 1'b1) begin
            tests_run++;
            if (bus.perr !== 1'b0) begin
                tests_failed++;
                $display("FAIL perr_width: perr=%b on 2nd cycle, required 0", bus.perr);
            end
        end
        if (bus.kstb === 1'b1) begin
            kstb_cnt++;
            kstb_cyc = cyc;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_kstb: code=%h make=%b ext=%b, required no strobe",
                         bus.code, bus.make, bus.ext);
            end else begin
                exp_ev = exp_q.pop_front();
                if ({bus.code, bus.make, bus.ext} !== exp_ev) begin
                    tests_failed++;
                    $display("FAIL event: code=%h make=%b ext=%b, required code=%h make=%b ext=%b",
                             bus.code, bus.make, bus.ext, exp_ev.code, exp_ev.make, exp_ev.ext);
                end
            end
        end
        if (bus.perr === 1'b1) perr_cnt++;
        kstb_prev = bus.kstb;
        perr_prev = bus.perr;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input bit bad_par,
                                          input bit bad_stop);
        logic p;
        p = ~(^b) ^ bad_par;
        return {~bad_stop, p, b, 1'b0};
    endfunction

    // Bits [first..last] of a frame, LSB (start bit) first.
    task automatic send_bits(input logic [10:0] v, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            ps2d = v[i];
            wait_clk(HALF);
            ps2ck    = 1'b0;
            fall_cyc = cyc;
            wait_clk(HALF);
            ps2ck = 1'b1;
        end
        ps2d = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(frame(b, 1'b0, 1'b0), 0, 10);
    endtask

    task automatic push_ev(input logic [7:0] c, input logic m, input logic x);
        ev_t e;
        e.code = c;
        e.make = m;
        e.ext  = x;
        exp_q.push_back(e);
    endtask

    // Bounded wait for outstanding strobes; leftovers show up as a wrong strobe count.
    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clock);
        exp_q.delete();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        wait_clk(4);
        tests_run++;
        if ({bus.kstb, bus.perr, bus.make, bus.code, bus.ext} !== {1'b0, 1'b0, 1'b1, 8'h00, 1'b0})
        begin
            tests_failed++;
            $display("FAIL reset_values: kstb=%b perr=%b make=%b code=%h ext=%b, required 0 0 1 00 0",
                     bus.kstb, bus.perr, bus.make, bus.code, bus.ext);
        end
        reset = 1'b1;
        wait_clk(5);
    endtask

    task automatic test_basic();
        int k0;
        int p0;
        k0 = kstb_cnt;
        p0 = perr_cnt;
        push_ev(8'h1C, 1'b1, 1'b0);
        send_byte(8'h1C);
        drain();
        tests_run++;
        if (kstb_cnt - k0 != 1) begin
            tests_failed++;
            $display("FAIL basic_kstb_count: got %0d, required 1", kstb_cnt - k0);
        end
        tests_run++;
        if (perr_cnt - p0 != 0) begin
            tests_failed++;
            $display("FAIL basic_perr_count: got %0d, required 0", perr_cnt - p0);
        end
        tests_run++;
        if (kstb_cyc - fall_cyc != int'(FILTER + 3)) begin
            tests_failed++;
            $display("FAIL latency: got %0d cycles, required %0d", kstb_cyc - fall_cyc, FILTER + 3);
        end
    endtask

    task automatic test_break();
        int k0;
        k0 = kstb_cnt;
        push_ev(8'h1C, 1'b0, 1'b0);
        send_byte(8'hF0);
        send_byte(8'h1C);
        push_ev(8'h1C, 1'b1, 1'b0);
        send_byte(8'hE1);
        send_byte(8'h1C);
        drain();
        tests_run++;
        if (kstb_cnt - k0 != 2) begin
            tests_failed++;
            $display("FAIL break_kstb_count: got %0d, required 2", kstb_cnt - k0);
        end
    endtask

    task automatic test_extended();
        int k0;
        int p0;
        k0 = kstb_cnt;
        p0 = perr_cnt;
        push_ev(8'h75, 1'b1, EXT_EN);
        send_byte(8'hE0);
        send_byte(8'h75);
        push_ev(8'h75, 1'b0, EXT_EN);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        drain();
        tests_run++;
        if (kstb_cnt - k0 != 2 || perr_cnt - p0 != 0) begin
            tests_failed++;
            $display("FAIL ext_counts: kstb %0d perr %0d, required 2 and 0",
                     kstb_cnt - k0, perr_cnt - p0);
        end
        wait_clk(10);
        tests_run++;
        if (bus.ext !== EXT_EN || bus.code !== 8'h75) begin
            tests_failed++;
            $display("FAIL ext_hold: ext=%b code=%h, required ext=%b code=75",
                     bus.ext, bus.code, EXT_EN);
        end
    endtask

    task automatic test_parity_error();
        int k0;
        int p0;
        k0 = kstb_cnt;
        p0 = perr_cnt;
        send_bits(frame(8'h1C, 1'b1, 1'b0), 0, 10);
        drain();
        tests_run++;
        if (kstb_cnt - k0 != 0 || perr_cnt - p0 != 1) begin
            tests_failed++;
            $display("FAIL parity_err: kstb %0d perr %0d, required 0 and 1",
                     kstb_cnt - k0, perr_cnt - p0);
        end
        tests_run++;
        if (bus.code !== 8'h75) begin
            tests_failed++;
            $display("FAIL code_hold: code=%h, required 75", bus.code);
        end
        // Break prefix must not survive a stop-bit error.
        k0 = kstb_cnt;
        p0 = perr_cnt;
        send_byte(8'hF0);
        send_bits(frame(8'h1C, 1'b0, 1'b1), 0, 10);
        push_ev(8'h29, 1'b1, 1'b0);
        send_byte(8'h29);
        drain();
        tests_run++;
        if (kstb_cnt - k0 != 1 || perr_cnt - p0 != 1) begin
            tests_failed++;
            $display("FAIL stop_err: kstb %0d perr %0d, required 1 and 1",
                     kstb_cnt - k0, perr_cnt - p0);
        end
    endtask

    task automatic test_timeout();
        int k0;
        int p0;
        k0 = kstb_cnt;
        p0 = perr_cnt;
        send_byte(8'hF0);
        send_bits(frame(8'h33, 1'b0, 1'b0), 0, 4);
        wait_clk(TIMEOUT + 10);
        #1;
        tests_run++;
        if (kstb_cnt - k0 != 0 || perr_cnt - p0 != 1) begin
            tests_failed++;
            $display("FAIL timeout: kstb %0d perr %0d, required 0 and 1",
                     kstb_cnt - k0, perr_cnt - p0);
        end
        k0 = kstb_cnt;
        push_ev(8'h5A, 1'b1, 1'b0);
        send_byte(8'h5A);
        drain();
        tests_run++;
        if (kstb_cnt - k0 != 1) begin
            tests_failed++;
            $display("FAIL after_timeout: kstb %0d, required 1", kstb_cnt - k0);
        end
    endtask

    task automatic test_reset_midframe();
        int k0;
        int p0;
        logic [10:0] v;
        v = frame(8'hF0, 1'b0, 1'b0);
        send_bits(v, 0, 5);
        reset = 1'b0;
        wait_clk(1);
        reset = 1'b1;
        #1;
        tests_run++;
        if ({bus.kstb, bus.perr, bus.make, bus.code, bus.ext} !== {1'b0, 1'b0, 1'b1, 8'h00, 1'b0})
        begin
            tests_failed++;
            $display("FAIL midframe_reset: kstb=%b perr=%b make=%b code=%h ext=%b, required 0 0 1 00 0",
                     bus.kstb, bus.perr, bus.make, bus.code, bus.ext);
        end
        k0 = kstb_cnt;
        p0 = perr_cnt;
        send_bits(v, 6, 10);
        push_ev(8'h1C, 1'b1, 1'b0);
        send_byte(8'h1C);
        drain();
        tests_run++;
        if (kstb_cnt - k0 != 1 || perr_cnt - p0 != 0) begin
            tests_failed++;
            $display("FAIL after_reset: kstb %0d perr %0d, required 1 and 0",
                     kstb_cnt - k0, perr_cnt - p0);
        end
    endtask

    task automatic test_glitch();
        int k0;
        int p0;
        k0 = kstb_cnt;
        p0 = perr_cnt;
        ps2d  = 1'b0;
        ps2ck = 1'b0;
        wait_clk(2);
        ps2ck = 1'b1;
        wait_clk(30);
        ps2d = 1'b1;
        wait_clk(10);
        push_ev(8'h1C, 1'b1, 1'b0);
        send_byte(8'h1C);
        drain();
        tests_run++;
        if (kstb_cnt - k0 != 1 || perr_cnt - p0 != 0) begin
            tests_failed++;
            $display("FAIL glitch: kstb %0d perr %0d, required 1 and 0",
                     kstb_cnt - k0, perr_cnt - p0);
        end
    endtask

    task automatic test_back_to_back();
        int k0;
        logic [7:0] b;
        k0 = kstb_cnt;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(1, 8'hDF));
            push_ev(b, 1'b1, 1'b0);
            send_byte(b);
        end
        drain();
        tests_run++;
        if (kstb_cnt - k0 != 6) begin
            tests_failed++;
            $display("FAIL back_to_back: kstb %0d, required 6", kstb_cnt - k0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_break();
        test_extended();
        test_parity_error();
        test_timeout();
        test_reset_midframe();
        test_glitch();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
